// File: rtl/fetch_queue.sv
// Instruction fetch unit: sequential PC generator feeding an in-order prefetch FIFO toward decode.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue #(
    parameter int               WIDTH       = 32,
    parameter int               INSTR_WIDTH = 32,
    parameter int               DEPTH       = 4,
    parameter int               STEP        = 4,
    parameter logic [WIDTH-1:0] RESET_PC    = {WIDTH{1'b0}}
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic                   imem_req,
    output logic [WIDTH-1:0]       imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0]       out_pc,
    output logic [WIDTH-1:0]       out_pc_next
);

    localparam int               AW      = $clog2(DEPTH);
    localparam int               CW      = AW + 1;
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [CW:0]      DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [WIDTH-1:0]       fetch_pc_r, fetch_pc_s;
    logic [INSTR_WIDTH-1:0] instr_q_r [DEPTH];
    logic [WIDTH-1:0]       pc_q_r [DEPTH];
    logic [AW-1:0]          rd_ptr_r, wr_ptr_r;
    logic [CW-1:0]          count_r, count_s, outst_r, outst_s;
    logic                   redirect_s, req_xfer_s, rsp_s, push_s, pop_s, pop_q_s, byp_s;
    logic [WIDTH-1:0]       rsp_pc_s, head_pc_s;

    // Handshakes, head selection and queue/counter/PC next values.
    always_comb begin
        redirect_s = redirect_valid && (state_r != IDLE);
        imem_req   = (state_r == RUN) && !redirect_s &&
                     (({1'b0, count_r} + {1'b0, outst_r}) < DEPTH_W);
        imem_addr  = fetch_pc_r;
        req_xfer_s = imem_req && imem_ready;
        rsp_s      = imem_rvalid && (outst_r != {CW{1'b0}});
        // Outstanding requests in RUN are the contiguous addresses just behind the fetch PC.
        rsp_pc_s   = fetch_pc_r - (WIDTH'(outst_r) * STEP_W);
`ifdef FETCH_QUEUE_BYPASS_EN
        byp_s      = (state_r == RUN) && !redirect_s && rsp_s && (count_r == {CW{1'b0}});
`else
        byp_s      = 1'b0;
`endif
        out_valid   = (count_r != {CW{1'b0}}) || byp_s;
        out_instr   = byp_s ? imem_rdata : instr_q_r[rd_ptr_r];
        head_pc_s   = byp_s ? rsp_pc_s : pc_q_r[rd_ptr_r];
        out_pc      = head_pc_s;
        out_pc_next = head_pc_s + STEP_W;
        pop_s      = out_valid && out_ready && !redirect_s;
        pop_q_s    = pop_s && !byp_s;
        push_s     = rsp_s && (state_r == RUN) && !redirect_s && !(byp_s && out_ready);
        outst_s    = outst_r + CW'(req_xfer_s) - CW'(rsp_s);
        if (redirect_s) begin
            count_s    = {CW{1'b0}};
            fetch_pc_s = redirect_pc;
        end else begin
            count_s = count_r + CW'(push_s) - CW'(pop_q_s);
            if (req_xfer_s) begin
                fetch_pc_s = fetch_pc_r + STEP_W;
            end else begin
                fetch_pc_s = fetch_pc_r;
            end
        end
    end

    // Next-state logic; stale responses after a redirect are drained before fetching resumes.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: state_s = RUN;
            RUN: begin
                if (redirect_s && (outst_s != {CW{1'b0}})) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (outst_s == {CW{1'b0}}) begin
                    state_s = RUN;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, counters, pointers and queue storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            count_r    <= {CW{1'b0}};
            outst_r    <= {CW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_q_r[i] <= {INSTR_WIDTH{1'b0}};
                pc_q_r[i]    <= RESET_PC;
            end
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            count_r    <= count_s;
            outst_r    <= outst_s;
            if (redirect_s) begin
                wr_ptr_r <= rd_ptr_r;
            end else if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_q_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_s) begin
                instr_q_r[wr_ptr_r] <= imem_rdata;
                pc_q_r[wr_ptr_r]    <= rsp_pc_s;
            end
        end
    end

endmodule
